// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported unified memory between instruction fetch and
// load/store. Data requests win by default; a pending fetch is forced through
// after STARVE_MAX consecutive data wins. Each access is sequenced through a
// fixed-latency IDLE -> ISSUE -> WAIT -> DONE walk. All outputs are registered.
module unified_mem_arbiter #(
    parameter int MEM_LAT    = 1,   // cycles from mem_en to valid mem_rdata, 1..15
    parameter int STARVE_MAX = 4    // data wins over a pending fetch before fetch is forced, 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        mem_en,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic       GRANT_FETCH = 1'b0;
    localparam logic       GRANT_DATA  = 1'b1;
    localparam logic [3:0] LAT_LOAD    = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM  = 4'(STARVE_MAX);

    state_t      state_reg, state_next;
    logic        grant_reg, grant_next;
    logic [3:0]  starve_cnt_reg, starve_cnt_next;
    logic [3:0]  lat_cnt_reg, lat_cnt_next;
    logic        flush_pend_reg, flush_pend_next;
    logic        mem_en_reg, mem_en_next;
    logic        mem_we_reg, mem_we_next;
    logic [1:0]  mem_size_reg, mem_size_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic [31:0] if_rdata_reg, if_rdata_next;
    logic [31:0] d_rdata_reg, d_rdata_next;
    logic        if_valid_reg, if_valid_next;
    logic        d_valid_reg, d_valid_next;
    logic        busy_reg, busy_next;

    // Arbitration: data wins unless the fetch has been starved to the limit.
    // A forced fetch that is flushed in the same cycle leaves nobody granted.
    logic data_win;
    logic fetch_win;
    assign data_win  = d_req && !(if_req && (starve_cnt_reg == STARVE_LIM));
    assign fetch_win = !data_win && if_req && !if_flush;

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= GRANT_FETCH;
            starve_cnt_reg <= '0;
            lat_cnt_reg    <= '0;
            flush_pend_reg <= 1'b0;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_size_reg   <= '0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            if_rdata_reg   <= '0;
            d_rdata_reg    <= '0;
            if_valid_reg   <= 1'b0;
            d_valid_reg    <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            starve_cnt_reg <= starve_cnt_next;
            lat_cnt_reg    <= lat_cnt_next;
            flush_pend_reg <= flush_pend_next;
            mem_en_reg     <= mem_en_next;
            mem_we_reg     <= mem_we_next;
            mem_size_reg   <= mem_size_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            if_rdata_reg   <= if_rdata_next;
            d_rdata_reg    <= d_rdata_next;
            if_valid_reg   <= if_valid_next;
            d_valid_reg    <= d_valid_next;
            busy_reg       <= busy_next;
        end
    end

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // so that each registered output is correct in the state it belongs to.
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        starve_cnt_next = starve_cnt_reg;
        lat_cnt_next    = lat_cnt_reg;
        flush_pend_next = flush_pend_reg;
        mem_en_next     = 1'b0;
        mem_we_next     = mem_we_reg;
        mem_size_next   = mem_size_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        if_rdata_next   = if_rdata_reg;
        d_rdata_next    = d_rdata_reg;
        if_valid_next   = 1'b0;
        d_valid_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                flush_pend_next = 1'b0;
                if (data_win) begin
                    grant_next     = GRANT_DATA;
                    mem_en_next    = 1'b1;
                    mem_we_next    = d_we;
                    mem_size_next  = d_size;
                    mem_addr_next  = d_addr;
                    mem_wdata_next = d_wdata;
                    state_next     = ISSUE;
                    if (if_req && (starve_cnt_reg < STARVE_LIM)) begin
                        starve_cnt_next = starve_cnt_reg + 4'd1;
                    end
                end else if (fetch_win) begin
                    grant_next      = GRANT_FETCH;
                    mem_en_next     = 1'b1;
                    mem_we_next     = 1'b0;
                    mem_size_next   = 2'b00;
                    mem_addr_next   = if_addr;
                    mem_wdata_next  = '0;
                    starve_cnt_next = '0;
                    state_next      = ISSUE;
                end
            end
            ISSUE: begin
                if (grant_reg == GRANT_FETCH && if_flush) begin
                    flush_pend_next = 1'b1;
                end
                lat_cnt_next = LAT_LOAD;
                state_next   = WAIT;
            end
            WAIT: begin
                if (grant_reg == GRANT_FETCH && if_flush) begin
                    flush_pend_next = 1'b1;
                end
                if (lat_cnt_reg == 4'd0) begin
                    state_next = DONE;
                    if (grant_reg == GRANT_DATA) begin
                        d_rdata_next = mem_we_reg ? 32'h0 : mem_rdata;
                        d_valid_next = 1'b1;
                    end else begin
                        // A flush arriving in this last WAIT cycle must also
                        // suppress the pulse, since if_valid is registered.
                        if_rdata_next = mem_rdata;
                        if_valid_next = !(flush_pend_reg || if_flush);
                    end
                end else begin
                    lat_cnt_next = lat_cnt_reg - 4'd1;
                end
            end
            DONE: begin
                flush_pend_next = 1'b0;
                state_next      = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign if_rdata  = if_rdata_reg;
    assign if_valid  = if_valid_reg;
    assign d_rdata   = d_rdata_reg;
    assign d_valid   = d_valid_reg;
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_size  = mem_size_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: stimulus pushes the expected
// access/response per transaction, a monitor checks every mem_en and every
// valid pulse against the queue head, a memory model answers after LAT cycles.
module tb_unified_mem_arbiter;

    localparam int LAT  = 3;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req, d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_en, mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    unified_mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_data;
        bit          flushed;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          issue_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input bit is_data, input bit flushed, input bit we,
                            input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int issue_cyc);
        exp_t e;
        e.is_data = is_data; e.flushed = flushed; e.we = we; e.size = size;
        e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.issue_cyc = issue_cyc;
        exp_q.push_back(e);
    endtask

    // Memory model: answers LAT cycles after mem_en, junk on all other cycles.
    logic [31:0] mem_model [logic [31:0]];
    initial begin
        logic [31:0] pend_addr;
        int          pend_cyc;
        mem_model[32'h10]  = 32'h0050_0093;
        mem_model[32'h14]  = 32'h0010_0073;
        mem_model[32'h100] = 32'h1234_ABCD;
        mem_model[32'h300] = 32'h1111_1111;
        mem_model[32'h304] = 32'h2222_2222;
        mem_model[32'h308] = 32'h3333_3333;
        mem_model[32'h30C] = 32'h4444_4444;
        mem_model[32'h310] = 32'h5A5A_5A5A;
        mem_model[32'h20]  = 32'h00A0_0113;
        mem_model[32'h24]  = 32'h00B0_0193;
        mem_model[32'h30]  = 32'h7777_0030;
        mem_model[32'h40]  = 32'h0000_006F;
        mem_model[32'h400] = 32'hCAFE_F00D;
        pend_addr = '0;
        pend_cyc  = -1;
        mem_rdata = 32'h5555_5555;
        forever begin
            @(posedge clk); #1;
            if (mem_en) begin
                pend_addr = mem_addr;
                pend_cyc  = cyc + LAT;
                if (mem_we) mem_model[mem_addr] = mem_wdata;
            end
            if (cyc == pend_cyc)
                mem_rdata = mem_model.exists(pend_addr) ? mem_model[pend_addr] : 32'h0;
            else
                mem_rdata = 32'h5555_5555;
        end
    end

    // Monitor: checks issues and responses against the head of the queue.
    initial begin
        exp_t e;
        bit   inflight = 1'b0;
        int   en_cyc = 0;
        int   busy_chk_cyc = -1;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                exp_q.delete();
                inflight = 1'b0;
                busy_chk_cyc = -1;
            end else begin
                if (mem_en) begin
                    if (inflight || exp_q.size() == 0) begin
                        n_vec++; n_miss++;
                        $display("FAIL unexpected_issue: mem_en=1 addr %h at cycle %0d, want no access", mem_addr, cyc);
                    end else begin
                        e = exp_q[0];
                        chk("issue_cycle", 32'(cyc), 32'(e.issue_cyc));
                        chk("mem_addr", mem_addr, e.addr);
                        chk("mem_size", {30'b0, mem_size}, {30'b0, e.size});
                        chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
                        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                        chk("busy_in_issue", {31'b0, busy}, 32'd1);
                        inflight = 1'b1;
                        en_cyc = cyc;
                    end
                end
                if (inflight && cyc == en_cyc + 1 + LAT) begin
                    e = exp_q.pop_front();
                    inflight = 1'b0;
                    busy_chk_cyc = cyc + 1;
                    if (e.is_data) begin
                        chk("d_valid", {31'b0, d_valid}, 32'd1);
                        chk("if_valid_quiet", {31'b0, if_valid}, 32'd0);
                        chk("d_rdata", d_rdata, e.rdata);
                    end else if (e.flushed) begin
                        chk("flushed_if_valid", {31'b0, if_valid}, 32'd0);
                        chk("d_valid_quiet", {31'b0, d_valid}, 32'd0);
                    end else begin
                        chk("if_valid", {31'b0, if_valid}, 32'd1);
                        chk("d_valid_quiet", {31'b0, d_valid}, 32'd0);
                        chk("if_rdata", if_rdata, e.rdata);
                    end
                    $display("txn %s%s addr=%h we=%0d size=%0d issue=%0d done=%0d d_rdata=%h if_rdata=%h",
                             e.is_data ? "data" : "fetch", e.flushed ? "(flushed)" : "",
                             e.addr, e.we, e.size, en_cyc, cyc, d_rdata, if_rdata);
                end else if (if_valid || d_valid) begin
                    n_vec++; n_miss++;
                    $display("FAIL spurious_valid: if_valid=%0d d_valid=%0d at cycle %0d, want 0", if_valid, d_valid, cyc);
                end
                if (cyc == busy_chk_cyc) chk("busy_after_done", {31'b0, busy}, 32'd0);
            end
        end
    end

    task automatic wait_valid(input bit is_data, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_data ? d_valid : if_valid) && n < 200);
        if (n >= 200) begin
            n_vec++; n_miss++;
            $display("FAIL %s_timeout: no valid pulse in 200 cycles, want one", name);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_vec++; n_miss++;
            $display("FAIL idle_timeout: busy=1 after 50 cycles, want 0");
        end
    endtask

    task automatic fetch_txn(input logic [31:0] addr);
        if_addr = addr;
        if_req  = 1'b1;
        wait_valid(1'b0, "fetch");
        if_req  = 1'b0;
    endtask

    task automatic data_txn(input bit we, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit keep);
        d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
        d_req = 1'b1;
        wait_valid(1'b1, "data");
        if (!keep) d_req = 1'b0;
    endtask

    function automatic logic [31:0] any_out();
        return {31'b0, |{mem_en, mem_we, mem_size, mem_addr, mem_wdata,
                         if_valid, d_valid, if_rdata, d_rdata, busy}};
    endfunction

    // Directed stimulus; issue cycles are hand-computed for LAT=3
    // (one transaction occupies ISSUE + 3 WAIT + DONE + IDLE = 6 cycles).
    initial begin
        int t;
        rst = 1'b1;
        if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_size = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs_zero", any_out(), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single fetch
        wait_idle(); t = cyc;
        push_exp(0, 0, 0, 2'b00, 32'h10, 32'h0, 32'h0050_0093, t + 1);
        fetch_txn(32'h10);

        // Concurrent load (half) and fetch: data first, fetch after DONE+IDLE
        wait_idle(); t = cyc;
        push_exp(1, 0, 0, 2'b10, 32'h100, 32'h0, 32'h1234_ABCD, t + 1);
        push_exp(0, 0, 0, 2'b00, 32'h14, 32'h0, 32'h0010_0073, t + 7);
        fork
            data_txn(1'b0, 2'b10, 32'h100, 32'h0, 1'b0);
            fetch_txn(32'h14);
        join

        // Store: memory echoes the written word, d_rdata must read 0
        wait_idle(); t = cyc;
        push_exp(1, 0, 1, 2'b00, 32'h200, 32'hDEAD_BEEF, 32'h0, t + 1);
        data_txn(1'b1, 2'b00, 32'h200, 32'hDEAD_BEEF, 1'b0);

        // Starvation: 4 loads, forced fetch, then data wins again (counter cleared)
        wait_idle(); t = cyc;
        push_exp(1, 0, 0, 2'b00, 32'h300, 32'h0, 32'h1111_1111, t + 1);
        push_exp(1, 0, 0, 2'b00, 32'h304, 32'h0, 32'h2222_2222, t + 7);
        push_exp(1, 0, 0, 2'b00, 32'h308, 32'h0, 32'h3333_3333, t + 13);
        push_exp(1, 0, 0, 2'b00, 32'h30C, 32'h0, 32'h4444_4444, t + 19);
        push_exp(0, 0, 0, 2'b00, 32'h20,  32'h0, 32'h00A0_0113, t + 25);
        push_exp(1, 0, 0, 2'b00, 32'h310, 32'h0, 32'h5A5A_5A5A, t + 31);
        push_exp(0, 0, 0, 2'b00, 32'h24,  32'h0, 32'h00B0_0193, t + 37);
        fork
            begin
                for (int k = 0; k < 5; k++)
                    data_txn(1'b0, 2'b00, 32'h300 + 32'(4 * k), 32'h0, k < 4);
            end
            begin
                fetch_txn(32'h20);
                fetch_txn(32'h24);
            end
        join

        // Fetch flushed in the IDLE cycle it is presented: nothing granted
        wait_idle();
        if_addr = 32'h50; if_req = 1'b1; if_flush = 1'b1;
        @(negedge clk);
        if_req = 1'b0; if_flush = 1'b0;
        chk("idle_flush_busy", {31'b0, busy}, 32'd0);
        chk("idle_flush_mem_en", {31'b0, mem_en}, 32'd0);

        // Flush during WAIT: access completes without if_valid
        wait_idle(); t = cyc;
        push_exp(0, 1, 0, 2'b00, 32'h30, 32'h0, 32'h0, t + 1);
        if_addr = 32'h30; if_req = 1'b1;
        repeat (3) @(negedge clk);
        if_flush = 1'b1; if_req = 1'b0;
        @(negedge clk);
        if_flush = 1'b0;
        wait_idle(); @(negedge clk); t = cyc;
        push_exp(0, 0, 0, 2'b00, 32'h40, 32'h0, 32'h0000_006F, t + 1);
        fetch_txn(32'h40);

        // Reset in the first WAIT cycle of a load, then re-request
        wait_idle(); t = cyc;
        push_exp(1, 0, 0, 2'b00, 32'h400, 32'h0, 32'hCAFE_F00D, t + 1);
        d_we = 1'b0; d_size = 2'b00; d_addr = 32'h400; d_wdata = '0; d_req = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        chk("midwait_reset_outputs_zero", any_out(), 32'd0);
        rst = 1'b0; t = cyc;
        push_exp(1, 0, 0, 2'b00, 32'h400, 32'h0, 32'hCAFE_F00D, t + 1);
        data_txn(1'b0, 2'b00, 32'h400, 32'h0, 1'b0);

        wait_idle();
        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
